spi_req_arbiter: RTL and testbench
==================================

Name: spi_req_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one 8-bit SPI master core among N_REQ requesters. It owns the per-slave chip-select lines and the CS setup/hold timing. It issues start pulses to the SPI master and returns received bytes and completion strobes to the granted requester. It sits between the application-side requesters (LED/pattern logic, config loaders) and the SPI master core.

Parameters:
N_REQ, 4, number of requesters and number of chip-select lines (2..8)
DATA_W, 8, SPI word width; must equal the master's shift-register width
CS_SETUP, 2, cycles of cs_n low before m_start is pulsed (>=1)
CS_HOLD, 2, cycles cs_n stays low after m_done (>=1)
TIMEOUT, 1023, max cycles waiting for m_done before abort
IDX_W, $clog2(N_REQ), grant index width (derived)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester transfer request, level
tx_data  in  N_REQ*DATA_W  flattened per-requester TX words, requester i at [i*DATA_W +: DATA_W]
gnt  out  N_REQ  one-hot grant, high from SETUP through HOLD
done  out  N_REQ  one-cycle completion strobe to the served requester
err  out  1  one-cycle strobe, coincident with done, when the transfer timed out
rx_data  out  DATA_W  last received word; valid when done is high, held until next capture
busy  out  1  high in any state other than IDLE
cs_n  out  N_REQ  active-low chip selects, at most one low
m_start  out  1  one-cycle start pulse to the SPI master
m_tx_data  out  DATA_W  word to the master, stable from SETUP until IDLE
m_busy  in  1  master busy
m_done  in  1  master one-cycle transfer-complete strobe
m_rx_data  in  DATA_W  master receive word, valid with m_done

Behaviour:
- Reset (async, rstn=0): state IDLE; gnt=0; done=0; err=0; m_start=0; busy=0; cs_n all 1; m_tx_data=0; rx_data=0; last=N_REQ-1, so requester 0 wins first. Reset mid-transfer deasserts cs_n immediately.
- States: IDLE, SETUP, START, WAIT, HOLD, RELEASE.
- IDLE: if req is nonzero, pick the first set bit scanning last+1, last+2, ... mod N_REQ. Latch the index and latch tx_data[idx] into m_tx_data, then go to SETUP. req is sampled only in IDLE.
- SETUP: cs_n[idx]=0 and gnt[idx]=1 from the first SETUP cycle. Stay CS_SETUP cycles, then go to START.
- START: m_start=1 for exactly one cycle, only if m_busy=0. Otherwise remain in START with m_start=0. Then go to WAIT and clear the timeout counter.
- WAIT: on m_done, capture m_rx_data into rx_data and go to HOLD. If the counter reaches TIMEOUT without m_done, set an abort flag and go to HOLD. If m_done arrives in the same cycle as expiry, m_done wins and there is no error.
- HOLD: keep cs_n low for CS_HOLD cycles, then go to RELEASE.
- RELEASE (1 cycle): done[idx]=1, and err=abort flag. cs_n all 1 and gnt 0 in this cycle. Update last=idx, clear the abort flag, and go to IDLE.
- Minimum one IDLE cycle between transfers, so cs_n is high for at least 2 cycles between slaves.
- Latency with req sampled in IDLE at cycle 0 and a cooperative master:
  - cs_n low at cycle 1
  - m_start at cycle CS_SETUP+1
  - done at cycle (m_done cycle)+CS_HOLD+1
- Deasserting req mid-transfer has no effect; the transfer completes. A requester holding req high is re-served only after the others, per round-robin.
- m_done outside WAIT is ignored.
- tx_data changes after latch do not affect m_tx_data.
- Counters: SETUP/HOLD counters sized $clog2(max(CS_SETUP,CS_HOLD)+1); timeout counter $clog2(TIMEOUT+1). Counters saturate and never wrap.

Decomposition:
- Shared package spi_arb_pkg holds the state encoding constants (IDLE..RELEASE, 3 bits) and default timing constants (CS_SETUP, CS_HOLD, TIMEOUT).
- One sub-module, rr_pick: combinational round-robin priority selector with inputs req and last, outputs idx and any.
- Sequencing FSM and counters live in spi_req_arbiter.

Test Plan:
- Single request: req=4'b0001, tx_data[0]=8'hA5; master returns 8'h3C after 16 cycles -> cs_n=4'b1110 from cycle 1, m_start at cycle 3, m_tx_data=8'hA5, done=4'b0001 with rx_data=8'h3C, err=0.
- Round-robin fairness: req=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3; never two cs_n low; >=2 high cycles between selects.
- m_busy held high 5 cycles after SETUP -> m_start delayed until the first cycle with m_busy=0; exactly one pulse.
- Timeout: master never asserts m_done, TIMEOUT=1023 -> err=1 together with done[idx] after 1023 WAIT cycles + CS_HOLD + 1; rx_data unchanged.
- Async reset asserted in WAIT with cs_n[2] low -> cs_n=4'b1111, gnt=0, m_start=0 without a clock edge; after release, req=4'b0101 serves requester 0 first.
- m_done coincident with timeout expiry -> rx_data captured, err=0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI requester arbiter: sequencer state encoding,
// default CS timing and small elaboration-time helpers.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RELEASE = 3'd5
  } arb_state_t;

  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_TIMEOUT  = 1023;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit scanning upward
// from the requester after the one served last, wrapping modulo N_REQ.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // k = N_REQ wraps back onto last itself, so a lone requester is re-served
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one SPI master core
// among N_REQ requesters; owns chip selects and CS setup/hold timing.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                    sys_clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] tx_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    err,
  output logic [DATA_W-1:0]       rx_data,
  output logic                    busy,
  output logic [N_REQ-1:0]        cs_n,
  output logic                    m_start,
  output logic [DATA_W-1:0]       m_tx_data,
  input  logic                    m_busy,
  input  logic                    m_done,
  input  logic [DATA_W-1:0]       m_rx_data
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max_int(CS_SETUP, CS_HOLD) + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [N_REQ-1:0]  pick_oh;
  logic [N_REQ-1:0]  idx_oh;
  logic [CNT_W-1:0]  cnt;
  logic [TMR_W-1:0]  tmr;
  logic              abort;
  logic [DATA_W-1:0] tx_word [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_tx_word
    assign tx_word[i] = tx_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req  (req),
    .last (last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign pick_oh = N_REQ'(1) << pick_idx;
  assign idx_oh  = N_REQ'(1) << idx;

  // m_start must react to m_busy in the same cycle, so it is decoded from state
  assign m_start = (state == ST_START) && !m_busy;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      idx       <= '0;
      last      <= IDX_W'(N_REQ - 1);
      cnt       <= '0;
      tmr       <= '0;
      abort     <= 1'b0;
      gnt       <= '0;
      cs_n      <= '1;
      done      <= '0;
      err       <= 1'b0;
      rx_data   <= '0;
      m_tx_data <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            idx       <= pick_idx;
            m_tx_data <= tx_word[pick_idx];
            gnt       <= pick_oh;
            cs_n      <= ~pick_oh;
            cnt       <= '0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= ST_START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_START: begin
          if (!m_busy) begin
            tmr   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // a completion arriving on the expiry cycle still counts as success
          if (m_done) begin
            rx_data <= m_rx_data;
            cnt     <= '0;
            state   <= ST_HOLD;
          end else if (tmr == TMR_LAST) begin
            abort <= 1'b1;
            cnt   <= '0;
            state <= ST_HOLD;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            gnt   <= '0;
            cs_n  <= '1;
            done  <= idx_oh;
            err   <= abort;
            state <= ST_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          last  <= idx;
          abort <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          gnt   <= '0;
          cs_n  <= '1;
          abort <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Randomized bench for spi_req_arbiter: transaction-level round-robin and
// timing model, with a simple SPI master responder driven from the bench.
module tb_spi_req_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int CSS = 2;
  localparam int CSH = 2;
  localparam int TO  = 1023;

  logic              sys_clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   tx_data;
  logic [N-1:0]      gnt;
  logic [N-1:0]      done;
  logic              err;
  logic [DW-1:0]     rx_data;
  logic              busy;
  logic [N-1:0]      cs_n;
  logic              m_start;
  logic [DW-1:0]     m_tx_data;
  logic              m_busy;
  logic              m_done;
  logic [DW-1:0]     m_rx_data;

  int            n_checks = 0;
  int            n_errors = 0;
  int            model_last;
  logic [DW-1:0] model_rx;

  always #5 sys_clk = ~sys_clk;

  spi_req_arbiter #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .CS_SETUP (CSS),
    .CS_HOLD  (CSH),
    .TIMEOUT  (TO)
  ) dut (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .req       (req),
    .tx_data   (tx_data),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rx_data   (rx_data),
    .busy      (busy),
    .cs_n      (cs_n),
    .m_start   (m_start),
    .m_tx_data (m_tx_data),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_rx_data (m_rx_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next requester after 'last' (wrapping) that has its request bit set.
  function automatic int rr_model(input logic [N-1:0] r, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (((r >> c) & N'(1)) != '0) return c;
    end
    return -1;
  endfunction

  // One transfer starting in an IDLE cycle. resp_delay: cycles from m_start to
  // m_done (outside 1..TO means the master never answers). rst_at: cycle at
  // which to pulse async reset mid-transfer (-1 for none).
  task automatic xfer(input logic [N-1:0] r, input logic [N*DW-1:0] txv,
                      input logic [DW-1:0] resp, input int busy_extra,
                      input int resp_delay, input int rst_at);
    int            idx;
    int            exp_start;
    int            exp_done;
    int            md;
    logic          exp_err;
    logic [N-1:0]  oh;
    logic [N-1:0]  exp_cs;
    logic [N-1:0]  exp_gnt;
    logic [DW-1:0] exp_tx;
    int            cs_bad;
    int            tx_bad;
    int            busy_bad;
    int            st_cnt;
    int            st_rel;
    int            dn_cnt;
    int            er_cnt;
    bit            aborted;
    cs_bad = 0; tx_bad = 0; busy_bad = 0; st_cnt = 0; st_rel = -1;
    dn_cnt = 0; er_cnt = 0; aborted = 1'b0;

    req     = r;
    tx_data = txv;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    idx     = rr_model(r, model_last);
    oh      = N'(1) << idx;
    exp_tx  = DW'(txv >> (idx * DW));
    exp_start = CSS + 1 + busy_extra;
    if (resp_delay < 1 || resp_delay > TO) begin
      md       = -1;
      exp_done = exp_start + TO + CSH + 1;
      exp_err  = 1'b1;
    end else begin
      md       = exp_start + resp_delay;
      exp_done = md + CSH + 1;
      exp_err  = 1'b0;
    end

    for (int rel = 1; rel <= exp_done; rel++) begin
      @(negedge sys_clk);
      m_busy    = (rel <= CSS + busy_extra);
      m_done    = (rel == 1) || (rel == md);
      m_rx_data = (rel == 1) ? ~resp : resp;
      tx_data   = (N*DW)'($urandom);
      if (rel >= 2) req = N'($urandom);
      #1;
      if (rel == rst_at) begin
        rstn   = 1'b0;
        req    = '0;
        m_done = 1'b0;
        m_busy = 1'b0;
        #1;
        check_eq("rst_cs_n", 32'(cs_n), 32'hF);
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_m_start", 32'(m_start), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        aborted = 1'b1;
        break;
      end
      exp_cs  = (rel < exp_done) ? ~oh : '1;
      exp_gnt = (rel < exp_done) ? oh : '0;
      if (rel == 1) check_eq("gnt_first", 32'(gnt), 32'(oh));
      if (cs_n !== exp_cs || gnt !== exp_gnt) cs_bad++;
      if (m_tx_data !== exp_tx) tx_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (m_start === 1'b1) begin
        st_cnt++;
        st_rel = rel;
      end
      if (done !== '0) dn_cnt++;
      if (err === 1'b1) er_cnt++;
      if (rel == exp_done) begin
        check_eq("done", 32'(done), 32'(oh));
        check_eq("err", 32'(err), 32'(exp_err));
        check_eq("rx_data", 32'(rx_data), exp_err ? 32'(model_rx) : 32'(resp));
      end
    end

    check_eq("start_cnt", st_cnt, 1);
    check_eq("cs_seq", cs_bad, 0);
    if (aborted) begin
      @(negedge sys_clk);
      rstn = 1'b1;
      model_last = N - 1;
      model_rx   = '0;
      @(negedge sys_clk);
      #1;
      check_eq("post_rst_tx", 32'(m_tx_data), 32'h0);
      check_eq("post_rst_rx", 32'(rx_data), 32'h0);
      return;
    end
    check_eq("start_cyc", st_rel, exp_start);
    check_eq("done_cnt", dn_cnt, 1);
    check_eq("err_cnt", er_cnt, int'(exp_err));
    check_eq("tx_hold", tx_bad, 0);
    check_eq("busy_hold", busy_bad, 0);
    model_last = idx;
    if (!exp_err) model_rx = resp;

    @(negedge sys_clk);
    m_done = 1'b0;
    m_busy = 1'b0;
    #1;
    check_eq("idle_busy", 32'(busy), 32'h0);
    check_eq("idle_cs_n", 32'(cs_n), 32'hF);
    check_eq("idle_done", 32'(done), 32'h0);
  endtask

  initial begin
    rstn      = 1'b0;
    req       = '0;
    tx_data   = '0;
    m_busy    = 1'b0;
    m_done    = 1'b0;
    m_rx_data = '0;
    repeat (2) @(negedge sys_clk);
    #1;
    check_eq("reset_gnt", 32'(gnt), 32'h0);
    check_eq("reset_cs_n", 32'(cs_n), 32'hF);
    check_eq("reset_done", 32'(done), 32'h0);
    check_eq("reset_err", 32'(err), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);
    check_eq("reset_m_start", 32'(m_start), 32'h0);
    check_eq("reset_m_tx", 32'(m_tx_data), 32'h0);
    check_eq("reset_rx", 32'(rx_data), 32'h0);
    @(negedge sys_clk);
    rstn       = 1'b1;
    model_last = N - 1;
    model_rx   = '0;
    @(negedge sys_clk);
    #1;

    xfer(4'b0001, 32'h000000A5, 8'h3C, 0, 16, -1);

    for (int t = 0; t < 8; t++)
      xfer(4'b1111, (N*DW)'($urandom), DW'($urandom), 0, $urandom_range(1, 20), -1);

    xfer(4'b0010, (N*DW)'($urandom), DW'($urandom), 5, 7, -1);

    for (int t = 0; t < 12; t++)
      xfer(N'($urandom_range(1, 15)), (N*DW)'($urandom), DW'($urandom),
           $urandom_range(0, 3), $urandom_range(1, 30), -1);

    xfer(N'($urandom_range(1, 15)), (N*DW)'($urandom), DW'($urandom), 0, 0, -1);
    xfer(N'($urandom_range(1, 15)), (N*DW)'($urandom), DW'($urandom), 1, TO, -1);
    xfer(4'b1010, (N*DW)'($urandom), DW'($urandom), 0, 3, -1);

    xfer(4'b0100, (N*DW)'($urandom), DW'($urandom), 0, 20, CSS + 4);
    xfer(4'b0101, (N*DW)'($urandom), DW'($urandom), 0, 5, -1);
    xfer(4'b0101, (N*DW)'($urandom), DW'($urandom), 0, 5, -1);

    req = '0;
    repeat (3) @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
